// File: rtl/thirty_two_bit_full_adder_if.sv
// rtl/thirty_two_bit_full_adder_if.sv - operand/result bundle for the 32-bit adder
//
// Purpose: groups the adder operands and registered results into one bus.
// Signals:
//   inA      [31:0]  addend A
//   inB      [31:0]  addend B
//   carryIn          carry into bit 0
//   sum      [31:0]  registered A + B + carryIn
//   carryOut         registered carry out of bit 31
// Modports:
//   master  drives operands, observes results
//   slave   the adder itself
interface thirty_two_bit_full_adder_if;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        carryIn;
  logic [31:0] sum;
  logic        carryOut;

  modport master (output inA, output inB, output carryIn, input sum, input carryOut);
  modport slave  (input inA, input inB, input carryIn, output sum, output carryOut);
endinterface

// File: rtl/thirty_two_bit_full_adder.sv
// rtl/thirty_two_bit_full_adder.sv - registered 32-bit ripple-carry adder
//
// Purpose: {carryOut, sum} <= inA + inB + carryIn, one cycle latency, one
// operand set per cycle. Built as a hierarchy of half-width stages:
// half adder -> 1-bit full adder -> 2/4/8/16/32-bit full adders.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears sum and carryOut
//   bus    slave side of thirty_two_bit_full_adder_if (operands in, results out)

module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fullAdder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  halfAdder hA (.a(a),  .b(b),   .s(s1), .c(c1));
  halfAdder hB (.a(s1), .b(cin), .s(s),  .c(c2));

  // At most one of the two half adders can generate a carry.
  assign cout = c1 | c2;
endmodule

module fullAdder2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  logic midCarry;

  fullAdder1 lo (.a(a[0]), .b(b[0]), .cin(cin),      .s(s[0]), .cout(midCarry));
  fullAdder1 hi (.a(a[1]), .b(b[1]), .cin(midCarry), .s(s[1]), .cout(cout));
endmodule

module fullAdder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic midCarry;

  fullAdder2 lo (.a(a[1:0]), .b(b[1:0]), .cin(cin),      .s(s[1:0]), .cout(midCarry));
  fullAdder2 hi (.a(a[3:2]), .b(b[3:2]), .cin(midCarry), .s(s[3:2]), .cout(cout));
endmodule

module fullAdder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic midCarry;

  fullAdder4 lo (.a(a[3:0]), .b(b[3:0]), .cin(cin),      .s(s[3:0]), .cout(midCarry));
  fullAdder4 hi (.a(a[7:4]), .b(b[7:4]), .cin(midCarry), .s(s[7:4]), .cout(cout));
endmodule

module fullAdder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic midCarry;

  fullAdder8 lo (.a(a[7:0]),  .b(b[7:0]),  .cin(cin),      .s(s[7:0]),  .cout(midCarry));
  fullAdder8 hi (.a(a[15:8]), .b(b[15:8]), .cin(midCarry), .s(s[15:8]), .cout(cout));
endmodule

module fullAdder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic midCarry;

  fullAdder16 lo (.a(a[15:0]),  .b(b[15:0]),  .cin(cin),      .s(s[15:0]),  .cout(midCarry));
  fullAdder16 hi (.a(a[31:16]), .b(b[31:16]), .cin(midCarry), .s(s[31:16]), .cout(cout));
endmodule

module thirty_two_bit_full_adder (
  input  logic                          clk,
  input  logic                          rst_n,
  thirty_two_bit_full_adder_if.slave    bus
);
  logic [31:0] coreSum;
  logic        coreCarry;

  fullAdder32 core (
    .a    (bus.inA),
    .b    (bus.inB),
    .cin  (bus.carryIn),
    .s    (coreSum),
    .cout (coreCarry)
  );

  // Reset wins over capture so an in-flight result is dropped when rst_n drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sum      <= 32'h0000_0000;
      bus.carryOut <= 1'b0;
    end else begin
      bus.sum      <= coreSum;
      bus.carryOut <= coreCarry;
    end
  end
endmodule

// File: tb/tb_thirty_two_bit_full_adder.sv
// tb/tb_thirty_two_bit_full_adder.sv - directed and random vectors for the 32-bit adder
module tb_thirty_two_bit_full_adder;
  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  thirty_two_bit_full_adder_if busIf ();

  thirty_two_bit_full_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkResult(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got co=%b sum=%h, expected co=%b sum=%h",
               tag, observed[32], observed[31:0], expected[32], expected[31:0]);
    end
  endtask

  // Drive one operand set, let one edge capture it, then check just after the edge.
  task automatic applyVec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [32:0] expected);
    busIf.inA     = a;
    busIf.inB     = b;
    busIf.carryIn = ci;
    @(posedge clk);
    #1;
    checkResult(tag, {busIf.carryOut, busIf.sum}, expected);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] refSum;

    vecCount  = 0;
    missCount = 0;

    // Reset holds outputs at zero even with all-ones operands.
    rst_n = 1'b0;
    applyVec("reset_edge1", 32'hffff_ffff, 32'hffff_ffff, 1'b1, 33'h0_0000_0000);
    applyVec("reset_edge2", 32'hffff_ffff, 32'hffff_ffff, 1'b1, 33'h0_0000_0000);
    rst_n = 1'b1;
    applyVec("reset_release", 32'hffff_ffff, 32'hffff_ffff, 1'b1, 33'h1_ffff_ffff);

    // Carry-in = 0
    applyVec("ci0_zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    applyVec("ci0_alt",     32'h5555_5555, 32'haaaa_aaaa, 1'b0, 33'h0_ffff_ffff);
    applyVec("ci0_ones_0",  32'hffff_ffff, 32'h0000_0000, 1'b0, 33'h0_ffff_ffff);
    applyVec("ci0_ones_1s", 32'hffff_ffff, 32'hffff_ffff, 1'b0, 33'h1_ffff_fffe);

    // Carry-in = 1
    applyVec("ci1_zero",    32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001);
    applyVec("ci1_alt",     32'h5555_5555, 32'haaaa_aaaa, 1'b1, 33'h1_0000_0000);
    applyVec("ci1_ones_0",  32'hffff_ffff, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    applyVec("ci1_ones_1s", 32'hffff_ffff, 32'hffff_ffff, 1'b1, 33'h1_ffff_ffff);

    // Subtraction via ~B + 1
    applyVec("sub_5_minus_7", 32'h0000_0005, 32'hffff_fff8, 1'b1, 33'h0_ffff_fffe);
    applyVec("sub_7_minus_5", 32'h0000_0007, 32'hffff_fffa, 1'b1, 33'h1_0000_0002);

    // Boundary carries
    applyVec("carry_16bit",  32'h0000_ffff, 32'h0000_0001, 1'b0, 33'h0_0001_0000);
    applyVec("carry_to_msb", 32'h7fff_ffff, 32'h0000_0001, 1'b0, 33'h0_8000_0000);

    // Random back-to-back stream with one mid-stream reset edge.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (i == 500) begin
        rst_n = 1'b0;
        applyVec("midstream_reset", ra, rb, rc, 33'h0_0000_0000);
        rst_n = 1'b1;
      end else begin
        refSum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
        applyVec(i == 501 ? "resume_after_reset" : "random", ra, rb, rc, refSum);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
